// File: rtl/spi_master_arb.sv
// Two-requester burst arbiter and byte sequencer in front of spi_master.
// Grants a whole burst round-robin, paces bytes via dv/ready, routes MISO back, aborts on a stall.
module spi_master_arb #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  input  logic [7:0]       i_byte0,
  input  logic [7:0]       i_byte1,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_take,
  output logic [7:0]       o_rx_byte,
  output logic [1:0]       o_rx_dv,
  output logic [1:0]       o_done,
  output logic [1:0]       o_err,
  output logic [7:0]       o_mosi_byte,
  output logic             o_mosi_dv,
  input  logic             i_mosi_ready,
  input  logic             i_miso_dv,
  input  logic [7:0]       i_miso_byte
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_gnt;
  logic             r_last;
  logic [LEN_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wdog;
  logic             r_err_flag;
  logic [7:0]       r_rx_byte;
  logic [1:0]       r_rx_dv;

  logic w_win;
  logic w_launch;
  logic w_timeout;

  // Winner index: on a tie the requester not served last goes first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_win = 1'b0;
    case (i_req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  assign w_launch  = (r_state == S_SEND) && i_mosi_ready;
  assign w_timeout = (r_wdog == WD_W'(TIMEOUT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|i_req) w_next = S_SEND;
      S_SEND:    if (i_mosi_ready) w_next = S_WAIT_RX;
      S_WAIT_RX: begin
        if (i_miso_dv)      w_next = (r_cnt == '0) ? S_DONE : S_SEND;
        else if (w_timeout) w_next = S_DONE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mosi_byte = 8'h00;
    if (r_gnt[0])      o_mosi_byte = i_byte0;
    else if (r_gnt[1]) o_mosi_byte = i_byte1;
  end

  assign o_mosi_dv = w_launch;
  assign o_take    = w_launch ? r_gnt : 2'b00;
  assign o_done    = (r_state == S_DONE) ? r_gnt : 2'b00;
  assign o_err     = (r_state == S_DONE && r_err_flag) ? r_gnt : 2'b00;
  assign o_gnt     = r_gnt;
  assign o_rx_dv   = r_rx_dv;
  assign o_rx_byte = r_rx_byte;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt      <= 2'b00;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_wdog     <= '0;
      r_err_flag <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_rx_dv    <= 2'b00;
    end else begin
      r_rx_dv <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_gnt <= w_win ? 2'b10 : 2'b01;
            r_cnt <= w_win ? i_len1 : i_len0;
          end
        end
        S_SEND: begin
          if (i_mosi_ready) r_wdog <= '0;
        end
        S_WAIT_RX: begin
          // Length is checked before the decrement, so cnt never wraps.
          if (i_miso_dv) begin
            r_rx_byte <= i_miso_byte;
            r_rx_dv   <= r_gnt;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end else if (w_timeout) begin
            r_err_flag <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_DONE: begin
          r_gnt      <= 2'b00;
          r_last     <= r_gnt[1];
          r_err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: a cycle table for one burst plus hand-written corner sequences.
module tb_spi_master_arb;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] i_req;
  logic [3:0] i_len0, i_len1;
  logic [7:0] i_byte0, i_byte1;
  logic [1:0] o_gnt, o_take, o_rx_dv, o_done, o_err;
  logic [7:0] o_rx_byte, o_mosi_byte;
  logic       o_mosi_dv;
  logic       i_mosi_ready, i_miso_dv;
  logic [7:0] i_miso_byte;

  int n_vec = 0;
  int n_bad = 0;

  spi_master_arb #(.LEN_W(4), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
    .i_byte0(i_byte0), .i_byte1(i_byte1), .o_gnt(o_gnt), .o_take(o_take),
    .o_rx_byte(o_rx_byte), .o_rx_dv(o_rx_dv), .o_done(o_done), .o_err(o_err),
    .o_mosi_byte(o_mosi_byte), .o_mosi_dv(o_mosi_dv), .i_mosi_ready(i_mosi_ready),
    .i_miso_dv(i_miso_dv), .i_miso_byte(i_miso_byte)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [7:0] byte0;
    logic       ready;
    logic       miso_dv;
    logic [7:0] miso_byte;
    logic [1:0] gnt;
    logic [1:0] take;
    logic       mosi_dv;
    logic [7:0] mosi_byte;
    logic [1:0] rx_dv;
    logic [7:0] rx_byte;
    logic [1:0] done;
    logic [1:0] err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_req = 2'b00; i_len0 = 4'd0; i_len1 = 4'd0;
    i_byte0 = 8'h00; i_byte1 = 8'h00; i_mosi_ready = 1'b0;
    i_miso_dv = 1'b0; i_miso_byte = 8'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Runs one burst for grant g with ready held high and the slave answering ~byte one cycle after launch.
  task automatic serve_burst(input logic [1:0] g, input int nbytes, input string tag);
    logic [7:0] b;
    bit ok;
    i_mosi_ready = 1'b1;
    i_miso_dv    = 1'b0;
    i_byte0      = 8'h40;
    i_byte1      = 8'h80;
    ok = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge i_clk);
      #1;
      if (o_gnt != 2'b00) begin ok = 1'b1; break; end
    end
    check({tag, "_gnt"}, 32'(o_gnt), 32'(g));
    if (!ok) return;
    for (int k = 0; k < nbytes; k++) begin
      b  = (g[1] ? 8'h80 : 8'h40) + 8'(k);
      ok = 1'b0;
      for (int t = 0; t < 8; t++) begin
        if (t > 0) begin @(negedge i_clk); #1; end
        if (o_mosi_dv) begin ok = 1'b1; break; end
      end
      check($sformatf("%s_launch%0d", tag, k), 32'({o_take, o_mosi_byte}), 32'({g, b}));
      if (!ok) return;
      @(negedge i_clk);
      i_byte0     = 8'h41 + 8'(k);
      i_byte1     = 8'h81 + 8'(k);
      i_miso_dv   = 1'b1;
      i_miso_byte = ~b;
      #1;
      check($sformatf("%s_nodv%0d", tag, k), 32'({o_mosi_dv, o_take}), 32'd0);
      @(negedge i_clk);
      i_miso_dv = 1'b0;
      #1;
      check($sformatf("%s_rx%0d", tag, k), 32'({o_rx_dv, o_rx_byte, o_done, o_err}),
            32'({g, ~b, (k == nbytes - 1) ? g : 2'b00, 2'b00}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    // req len0 byte0 rdy mdv mbyte | gnt take mdv mbyte rxdv rxbyte done err
    vecs[0]  = '{2'b00, 4'd0, 8'hA5, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00};
    vecs[1]  = '{2'b01, 4'd2, 8'hA5, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00};
    vecs[2]  = '{2'b00, 4'd0, 8'hA5, 1'b1, 1'b0, 8'h00, 2'b01, 2'b01, 1'b1, 8'hA5, 2'b00, 8'h00, 2'b00, 2'b00};
    vecs[3]  = '{2'b00, 4'd0, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00};
    vecs[4]  = '{2'b00, 4'd0, 8'h3C, 1'b1, 1'b1, 8'hA5, 2'b01, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00};
    vecs[5]  = '{2'b00, 4'd0, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b01, 2'b01, 1'b1, 8'h3C, 2'b01, 8'hA5, 2'b00, 2'b00};
    vecs[6]  = '{2'b00, 4'd0, 8'hFF, 1'b1, 1'b1, 8'h3C, 2'b01, 2'b00, 1'b0, 8'h00, 2'b00, 8'hA5, 2'b00, 2'b00};
    vecs[7]  = '{2'b00, 4'd0, 8'hFF, 1'b1, 1'b0, 8'h00, 2'b01, 2'b01, 1'b1, 8'hFF, 2'b01, 8'h3C, 2'b00, 2'b00};
    vecs[8]  = '{2'b00, 4'd0, 8'hFF, 1'b1, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00, 2'b00, 8'h3C, 2'b00, 2'b00};
    vecs[9]  = '{2'b00, 4'd0, 8'hFF, 1'b1, 1'b1, 8'hFF, 2'b01, 2'b00, 1'b0, 8'h00, 2'b00, 8'h3C, 2'b00, 2'b00};
    vecs[10] = '{2'b00, 4'd0, 8'hFF, 1'b1, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00, 2'b01, 8'hFF, 2'b01, 2'b00};
    vecs[11] = '{2'b00, 4'd0, 8'hFF, 1'b1, 1'b1, 8'h77, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 8'hFF, 2'b00, 2'b00};
    vecs[12] = '{2'b00, 4'd0, 8'hFF, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 8'hFF, 2'b00, 2'b00};

    do_reset();

    // Single 3-byte burst for requester 0, cycle by cycle.
    for (int i = 0; i < 13; i++) begin
      @(negedge i_clk);
      i_req = vecs[i].req; i_len0 = vecs[i].len0; i_byte0 = vecs[i].byte0;
      i_mosi_ready = vecs[i].ready; i_miso_dv = vecs[i].miso_dv; i_miso_byte = vecs[i].miso_byte;
      #1;
      check($sformatf("vec%0d", i),
            32'({o_gnt, o_take, o_mosi_dv, (vecs[i].mosi_dv ? o_mosi_byte : 8'h00),
                 o_rx_dv, o_rx_byte, o_done, o_err}),
            32'({vecs[i].gnt, vecs[i].take, vecs[i].mosi_dv, vecs[i].mosi_byte,
                 vecs[i].rx_dv, vecs[i].rx_byte, vecs[i].done, vecs[i].err}));
    end

    // Tie straight out of reset: 0 first, one idle cycle, then 1.
    do_reset();
    @(negedge i_clk);
    i_req = 2'b11; i_len0 = 4'd0; i_len1 = 4'd0;
    serve_burst(2'b01, 1, "tie0");
    @(negedge i_clk); #1;
    check("tie_gap", 32'(o_gnt), 32'd0);
    serve_burst(2'b10, 1, "tie1");
    @(negedge i_clk);
    i_req = 2'b00;

    // Fairness: 0 holds its request, 1 joins mid-burst.
    @(negedge i_clk);
    i_req = 2'b01; i_len0 = 4'd1; i_len1 = 4'd0;
    #1;
    check("fair_idle", 32'(o_gnt), 32'd0);
    @(negedge i_clk);
    i_req = 2'b11;
    serve_burst(2'b01, 2, "fair0");
    @(negedge i_clk); #1;
    check("fair_gap", 32'(o_gnt), 32'd0);
    serve_burst(2'b10, 1, "fair1");
    @(negedge i_clk);
    serve_burst(2'b01, 2, "fair2");
    @(negedge i_clk);
    i_req = 2'b00;

    // Backpressure: ready low for 5 SEND cycles, byte must survive.
    @(negedge i_clk);
    i_req = 2'b01; i_len0 = 4'd0; i_byte0 = 8'hC3; i_mosi_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      i_req = 2'b00;
      #1;
      check($sformatf("bp_stall%0d", k), 32'({o_gnt, o_mosi_dv, o_take}), 32'({2'b01, 1'b0, 2'b00}));
    end
    @(negedge i_clk);
    i_mosi_ready = 1'b1;
    #1;
    check("bp_launch", 32'({o_take, o_mosi_dv, o_mosi_byte}), 32'({2'b01, 1'b1, 8'hC3}));
    @(negedge i_clk);
    i_miso_dv = 1'b1; i_miso_byte = 8'h5C;
    @(negedge i_clk);
    i_miso_dv = 1'b0;
    #1;
    check("bp_rx", 32'({o_rx_dv, o_rx_byte, o_done, o_err}), 32'({2'b01, 8'h5C, 2'b01, 2'b00}));

    // Timeout: no MISO for a 4-byte burst of requester 1; err lands 10 cycles after launch.
    @(negedge i_clk);
    i_req = 2'b10; i_len1 = 4'd3; i_byte1 = 8'hE7; i_mosi_ready = 1'b1;
    @(negedge i_clk);
    i_req = 2'b00;
    #1;
    check("to_launch", 32'({o_gnt, o_take, o_mosi_dv, o_mosi_byte}), 32'({2'b10, 2'b10, 1'b1, 8'hE7}));
    for (int k = 1; k < 10; k++) begin
      @(negedge i_clk); #1;
      check($sformatf("to_wait%0d", k), 32'({o_done, o_err, o_rx_dv, o_mosi_dv}), 32'd0);
    end
    @(negedge i_clk); #1;
    check("to_abort", 32'({o_done, o_err, o_gnt}), 32'({2'b10, 2'b10, 2'b10}));
    @(negedge i_clk);
    i_req = 2'b01; i_len0 = 4'd0;
    #1;
    check("to_release", 32'(o_gnt), 32'd0);
    serve_burst(2'b01, 1, "post_to");
    @(negedge i_clk);
    i_req = 2'b00;

    // Reset in WAIT_RX of a 4-byte burst, then a late MISO byte.
    @(negedge i_clk);
    i_req = 2'b01; i_len0 = 4'd3; i_byte0 = 8'h99;
    @(negedge i_clk);
    i_req = 2'b00;
    #1;
    check("rst_launch", 32'({o_take, o_mosi_dv}), 32'({2'b01, 1'b1}));
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_clear", 32'({o_gnt, o_take, o_mosi_dv, o_mosi_byte, o_rx_dv, o_rx_byte, o_done, o_err}), 32'd0);
    @(negedge i_clk);
    i_miso_dv = 1'b1; i_miso_byte = 8'h66;
    @(negedge i_clk);
    i_miso_dv = 1'b0;
    #1;
    check("late_miso", 32'({o_rx_dv, o_rx_byte, o_gnt}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
